// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and digit/vector validity helpers
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

  function automatic logic bcd_vec_valid(input logic [31:0] v, input int n);
    for (int i = 0; i < 8; i++)
      if (i < n && !bcd_digit_valid(v[i*BCD_W+:BCD_W])) return 1'b0;
    return 1'b1;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD digit step with carry/borrow ripple
import bcd_pkg::*;
module bcd_digit_cell (
  input  logic [3:0] digit,
  input  logic       dir,
  input  logic       step_in,
  output logic [3:0] next,
  output logic       step_out
);
  logic [3:0] up_v, dn_v;
  // wrap the digit at 9/0 and ripple a carry or borrow when it does
  always_comb begin
    up_v = (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    dn_v = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    next = step_in ? (dir ? up_v : dn_v) : digit;
    step_out = step_in & (dir ? (digit == BCD_MAX) : (digit == 4'd0));
  end
endmodule

// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: cascaded BCD up/down counter with programmable wrap limit
import bcd_pkg::*;
module bcd_counter_multi #(
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  EN,
  input  logic                  DIR,
  input  logic                  LOAD_EN,
  input  logic [4*DIGITS-1:0]   LOAD,
  input  logic [4*DIGITS-1:0]   LIMIT,
  output logic [4*DIGITS-1:0]   OUT,
  output logic                  OF,
  output logic                  UF,
  output logic                  LOAD_ERR,
  output logic                  AT_MAX,
  output logic                  AT_ZERO
);
  localparam int W = 4 * DIGITS;
  logic [W-1:0] out_q, out_d, elim, nxt;
  logic of_q, of_d, uf_q, uf_d, err_q, err_d, load_ok;
  logic [DIGITS:0] step;
  assign step[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_cell u_cell (
      .digit   (out_q[i*4+:4]),
      .dir     (DIR),
      .step_in (step[i]),
      .next    (nxt[i*4+:4]),
      .step_out(step[i+1])
    );
  end
  // an invalid limit digit falls back to the full all-nines range
  always_comb begin
    elim = bcd_vec_valid(32'(LIMIT), DIGITS) ? LIMIT : {DIGITS{4'h9}};
    load_ok = bcd_vec_valid(32'(LOAD), DIGITS) && (LOAD <= elim);
  end
  // next-state selection: load, then count with wrap, else hold
  always_comb begin
    out_d = out_q;
    of_d = 1'b0;
    uf_d = 1'b0;
    err_d = 1'b0;
    if (LOAD_EN) begin
      out_d = load_ok ? LOAD : out_q;
      err_d = !load_ok;
    end else if (EN && DIR) begin
      of_d = out_q >= elim;
      out_d = of_d ? '0 : nxt;
    end else if (EN) begin
      uf_d = out_q == '0;
      out_d = uf_d ? elim : nxt;
    end
  end
  // state and pulse registers with synchronous clear
  always_ff @(posedge CLK) begin
    if (CLR) begin
      out_q <= '0;
      of_q <= 1'b0;
      uf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      of_q <= of_d;
      uf_q <= uf_d;
      err_q <= err_d;
    end
  end
  assign OUT = out_q;
  assign OF = of_q;
  assign UF = uf_q;
  assign LOAD_ERR = err_q;
  assign AT_MAX = out_q == elim;
  assign AT_ZERO = out_q == '0;
endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb_bcd_counter_multi: directed vector checks for 2- and 4-digit counters
module tb_bcd_counter_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr2, en2, dir2, ld2;
  logic [7:0] load2, lim2, out2;
  logic of2, uf2, err2, max2, zero2;
  logic clr4, en4, dir4, ld4;
  logic [15:0] load4, lim4, out4;
  logic of4, uf4, err4, max4, zero4;

  bcd_counter_multi #(.DIGITS(2)) d2 (
    .CLK(clk), .CLR(clr2), .EN(en2), .DIR(dir2), .LOAD_EN(ld2), .LOAD(load2),
    .LIMIT(lim2), .OUT(out2), .OF(of2), .UF(uf2), .LOAD_ERR(err2),
    .AT_MAX(max2), .AT_ZERO(zero2)
  );
  bcd_counter_multi #(.DIGITS(4)) d4 (
    .CLK(clk), .CLR(clr4), .EN(en4), .DIR(dir4), .LOAD_EN(ld4), .LOAD(load4),
    .LIMIT(lim4), .OUT(out4), .OF(of4), .UF(uf4), .LOAD_ERR(err4),
    .AT_MAX(max4), .AT_ZERO(zero4)
  );

  typedef struct {
    logic clr, en, dir, ld;
    logic [7:0] load, lim, out;
    logic of_e, uf_e, err_e, max_e, zero_e;
  } vec_t;
  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic c, e, d, l, input logic [7:0] ldv, lm, o,
                     input logic f, u, r, m, z);
    vq.push_back('{c, e, d, l, ldv, lm, o, f, u, r, m, z});
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  task automatic drive4(input logic c, e, d, l, input logic [15:0] ldv, lm);
    clr4 = c; en4 = e; dir4 = d; ld4 = l; load4 = ldv; lim4 = lm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr2 = 0; en2 = 0; dir2 = 0; ld2 = 0; load2 = 0; lim2 = 8'h59;
    clr4 = 0; en4 = 0; dir4 = 0; ld4 = 0; load4 = 0; lim4 = 16'h9999;
    //  clr en dir ld load   lim    out    of uf er mx zr
    add(1, 0, 0, 0, 8'h00, 8'h59, 8'h00, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 8'h45, 8'h59, 8'h45, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 8'h42, 8'h59, 8'h00, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 8'h58, 8'h59, 8'h58, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 8'h59, 8'h59, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 8'h00, 8'h59, 8'h00, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 8'h59, 8'h01, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h19, 8'h59, 8'h19, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 8'h59, 8'h20, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h10, 8'h59, 8'h10, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h59, 8'h09, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h59, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 8'h59, 8'h59, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00, 8'h59, 8'h58, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h3A, 8'h59, 8'h58, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 8'h60, 8'h59, 8'h58, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 8'h42, 8'h59, 8'h42, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h45, 8'h59, 8'h45, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 8'h30, 8'h00, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 8'h45, 8'h59, 8'h45, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h30, 8'h44, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h99, 8'hFF, 8'h99, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 1);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h59, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < vq.size(); i++) begin
      clr2 = vq[i].clr; en2 = vq[i].en; dir2 = vq[i].dir; ld2 = vq[i].ld;
      load2 = vq[i].load; lim2 = vq[i].lim;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d OUT", i), 32'(out2), 32'(vq[i].out));
      chk($sformatf("v%0d OF", i), 32'(of2), 32'(vq[i].of_e));
      chk($sformatf("v%0d UF", i), 32'(uf2), 32'(vq[i].uf_e));
      chk($sformatf("v%0d LOAD_ERR", i), 32'(err2), 32'(vq[i].err_e));
      chk($sformatf("v%0d AT_MAX", i), 32'(max2), 32'(vq[i].max_e));
      chk($sformatf("v%0d AT_ZERO", i), 32'(zero2), 32'(vq[i].zero_e));
    end
    drive4(1, 0, 0, 0, 16'h0000, 16'h9999);
    chk("d4 reset OUT", 32'(out4), 32'h0000);
    chk("d4 reset AT_ZERO", 32'(zero4), 32'h1);
    drive4(0, 0, 0, 1, 16'h0999, 16'h9999);
    chk("d4 load 0999", 32'(out4), 32'h0999);
    drive4(0, 1, 1, 0, 16'h0000, 16'h9999);
    chk("d4 carry OUT", 32'(out4), 32'h1000);
    chk("d4 carry OF", 32'(of4), 32'h0);
    drive4(0, 0, 0, 1, 16'h0000, 16'h9999);
    chk("d4 load 0000", 32'(out4), 32'h0000);
    drive4(0, 1, 0, 0, 16'h0000, 16'h9999);
    chk("d4 underflow OUT", 32'(out4), 32'h9999);
    chk("d4 underflow UF", 32'(uf4), 32'h1);
    chk("d4 underflow AT_MAX", 32'(max4), 32'h1);
    drive4(0, 1, 0, 0, 16'h0000, 16'h9999);
    chk("d4 down OUT", 32'(out4), 32'h9998);
    chk("d4 down UF clear", 32'(uf4), 32'h0);
    drive4(0, 0, 0, 1, 16'h0000, 16'h9999);
    for (int k = 0; k < 3; k++) begin
      drive4(0, 1, 1, 0, 16'h0000, 16'h0000);
      chk($sformatf("d4 lim0 OUT %0d", k), 32'(out4), 32'h0000);
      chk($sformatf("d4 lim0 OF %0d", k), 32'(of4), 32'h1);
    end
    drive4(0, 0, 0, 1, 16'h1234, 16'h1000);
    chk("d4 load over limit ERR", 32'(err4), 32'h1);
    chk("d4 load over limit OUT", 32'(out4), 32'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
